regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter: DATA_W, 16, register width in bits.
REQ-002 Parameter: NUM_REGS, 8, number of registers (power of two, >=4); ADDR_W = clog2(NUM_REGS).
REQ-003 Parameter: R1_INIT, 16'h0004, reset value of R1 (zero-extended/truncated to DATA_W).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 re  input  1  read enable; samples both read ports this cycle.
REQ-007 ra1, ra2  input  ADDR_W each  read addresses.
REQ-008 rd1, rd2  output  DATA_W each  registered read data.
REQ-009 we, wa, wd  input  1 / ADDR_W / DATA_W  general write port.
REQ-010 pc_we, pc_next  input  1 / DATA_W  PC (R0) update.
REQ-011 pc  output  DATA_W  current R0 value, combinational from storage.
REQ-012 rsv_en, rsv_a  input  1 / ADDR_W  scoreboard reserve (mark destination pending).
REQ-013 busy1, busy2  output  1 each  registered pending flag of the register read on ra1/ra2.

Function
REQ-014 R0 is the program counter; the SHALL be written only via pc_we; we with wa==0 is ignored.
REQ-015 we=1 and wa!=0: reg[wa] <= wd at the rising edge.
REQ-016 pc_we=1: reg[0] <= pc_next at the rising edge; independent of the general write port.
REQ-017 re=1: rd1/rd2/busy1/busy2 load next edge from ra1/ra2 (latency 1); re=0: all four hold.
REQ-018 Read of R0 returns current PC (pre-update value if pc_we same cycle, unless bypass per REQ-028).
REQ-019 Scoreboard: one busy bit per register; rsv_en=1 and rsv_a!=0 sets busy[rsv_a].
REQ-020 we=1 and wa!=0 clears busy[wa].
REQ-021 rsv_en and we to same address same cycle: busy set (new reservation wins); data still written.
REQ-022 busy[0] constant 0; rsv_a==0 ignored.
REQ-023 busy1/busy2 reflect busy bits after same-cycle clear by we (a completing write is not reported busy) but before same-cycle reserve.
REQ-024 Same-address reads on both ports return identical data.

Reset
REQ-025 reset asserted: R1 = R1_INIT, all other registers 0, busy bits 0, rd1=rd2=0, busy1=busy2=0, immediately and asynchronously.
REQ-026 reset dominates we, pc_we, rsv_en, re in any cycle it is high; reservations in flight are lost.
REQ-027 First rising edge after reset deassertion behaves as a normal cycle.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN defined: read in same cycle as write to same address returns wd (and pc_next for R0 with pc_we); undefined: returns old stored value (read-before-write). Busy semantics (REQ-023) identical in both builds.

Verification
REQ-029 Reset pulse mid-run -> pc=0, R1 read returns 0004, R2..R7 read 0, all busy 0.
REQ-030 we=1 wa=3 wd=ABCD, next cycle re=1 ra1=3 -> rd1=ABCD one edge later; we wa=0 wd=FFFF -> R0 unchanged.
REQ-031 Same-cycle we wa=5 wd=1234 and re ra2=5 (R5=0) -> rd2=1234 with REGFILE_BYPASS_EN, 0000 without.
REQ-032 rsv_en rsv_a=4; re ra1=4 -> busy1=1; later we wa=4 with re ra1=4 same cycle -> busy1=0.
REQ-033 rsv_en rsv_a=6 and we wa=6 same cycle, then re ra1=6 -> busy1=1, rd1=written data.
REQ-034 pc_we pc_next=0010 with re ra1=0 same cycle -> rd1=old PC (no bypass) or 0010 (bypass); pc=0010 after edge.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: R0 doubles as the PC, two registered read ports, one write port
// and a per-register pending scoreboard. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_mp #(
    parameter int          DATA_W   = 16,
    parameter int          NUM_REGS = 8,
    parameter logic [31:0] R1_INIT  = 32'h0004,
    localparam int         ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              pc_we,
    input  logic [DATA_W-1:0] pc_next,
    output logic [DATA_W-1:0] pc,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_a,
    output logic              busy1,
    output logic              busy2
);

    localparam logic [DATA_W-1:0] R1_RST = DATA_W'(R1_INIT);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_busy1;
    logic              r_busy2;

    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd1_next;
    logic [DATA_W-1:0] w_rd2_next;
    logic              w_busy1_next;
    logic              w_busy2_next;

    // R0 is owned by the PC path, so the general port never touches it.
    assign w_wr_en = we && (wa != '0);

    always_comb begin
        w_rd1_next = r_regs[ra1];
        w_rd2_next = r_regs[ra2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (wa == ra1)) w_rd1_next = wd;
        if (w_wr_en && (wa == ra2)) w_rd2_next = wd;
        if (pc_we && (ra1 == '0))   w_rd1_next = pc_next;
        if (pc_we && (ra2 == '0))   w_rd2_next = pc_next;
`endif
        // A completing write hides the pending flag; a same-cycle reserve is not yet visible.
        w_busy1_next = r_busy[ra1] && !(w_wr_en && (wa == ra1));
        w_busy2_next = r_busy[ra2] && !(w_wr_en && (wa == ra2));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[1] <= R1_RST;
            r_busy    <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_busy1   <= 1'b0;
            r_busy2   <= 1'b0;
        end else begin
            if (pc_we) begin
                r_regs[0] <= pc_next;
            end
            // Bit 0 of r_busy is never set, so R0 can never read as pending.
            for (int i = 1; i < NUM_REGS; i++) begin
                if (w_wr_en && (wa == ADDR_W'(i))) begin
                    r_regs[i] <= wd;
                end
                if (rsv_en && (rsv_a == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_en && (wa == ADDR_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
            if (re) begin
                r_rd1   <= w_rd1_next;
                r_rd2   <= w_rd2_next;
                r_busy1 <= w_busy1_next;
                r_busy2 <= w_busy2_next;
            end
        end
    end

    assign pc    = r_regs[0];
    assign rd1   = r_rd1;
    assign rd2   = r_rd2;
    assign busy1 = r_busy1;
    assign busy2 = r_busy2;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic checked against an
// array-based reference model of the register file and its pending scoreboard.
module tb_regfile_mp;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              re;
    logic [ADDR_W-1:0] ra1, ra2;
    logic [DATA_W-1:0] rd1, rd2;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              pc_we;
    logic [DATA_W-1:0] pc_next;
    logic [DATA_W-1:0] pc;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_a;
    logic              busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DATA_W-1:0] m_regs [NUM_REGS];
    logic              m_busy [NUM_REGS];
    logic [DATA_W-1:0] m_rd1, m_rd2;
    logic              m_b1, m_b2;

    regfile_mp dut (
        .clk(clk), .reset(reset), .re(re), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .pc_we(pc_we), .pc_next(pc_next), .pc(pc),
        .rsv_en(rsv_en), .rsv_a(rsv_a), .busy1(busy1), .busy2(busy2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_regs[1] = 16'h0004;
        m_rd1 = '0; m_rd2 = '0; m_b1 = 1'b0; m_b2 = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (BYPASS && a == 0 && pc_we) return pc_next;
        if (BYPASS && a != 0 && we && wa == a) return wd;
        return m_regs[a];
    endfunction

    // Drives one clock with the currently applied inputs and advances the model, then idles enables.
    task automatic tick();
        logic [DATA_W-1:0] n_rd1, n_rd2;
        logic              n_b1, n_b2;
        n_rd1 = m_rd1; n_rd2 = m_rd2; n_b1 = m_b1; n_b2 = m_b2;
        if (re) begin
            n_rd1 = model_read(ra1);
            n_rd2 = model_read(ra2);
            n_b1  = m_busy[ra1] && !(we && wa != 0 && wa == ra1);
            n_b2  = m_busy[ra2] && !(we && wa != 0 && wa == ra2);
        end
        @(posedge clk);
        m_rd1 = n_rd1; m_rd2 = n_rd2; m_b1 = n_b1; m_b2 = n_b2;
        if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
        end
        if (pc_we) m_regs[0] = pc_next;
        if (rsv_en && rsv_a != 0) m_busy[rsv_a] = 1'b1;
        #1;
        re = 1'b0; we = 1'b0; pc_we = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        re = 0; ra1 = 0; ra2 = 0; we = 0; wa = 0; wd = 0;
        pc_we = 0; pc_next = 0; rsv_en = 0; rsv_a = 0;
        model_reset();
        #2;
        n_checks++; if (rd1 !== 16'h0 || rd2 !== 16'h0) begin n_fail++; $display("FAIL reset_rd: got %h/%h expected 0000/0000", rd1, rd2); end
        n_checks++; if (busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy1, busy2); end
        n_checks++; if (pc !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", pc); end
        @(posedge clk); #1;
        reset = 1'b0;
        re = 1; ra1 = 1; ra2 = 2;
        tick();
        n_checks++; if (rd1 !== 16'h0004) begin n_fail++; $display("FAIL reset_r1: got %h expected 0004", rd1); end
        n_checks++; if (rd2 !== 16'h0000) begin n_fail++; $display("FAIL reset_r2: got %h expected 0000", rd2); end
    endtask

    task automatic test_write_read();
        we = 1; wa = 3; wd = 16'hABCD;
        tick();
        re = 1; ra1 = 3; ra2 = 1;
        tick();
        n_checks++; if (rd1 !== 16'hABCD) begin n_fail++; $display("FAIL wr_rd_r3: got %h expected abcd", rd1); end
        n_checks++; if (rd2 !== m_rd2) begin n_fail++; $display("FAIL wr_rd_r1: got %h expected %h", rd2, m_rd2); end
        we = 1; wa = 0; wd = 16'hFFFF;
        tick();
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("FAIL wr_r0_ignored: pc got %h expected 0000", pc); end
        re = 1; ra1 = 0; ra2 = 0;
        tick();
        n_checks++; if (rd1 !== 16'h0000 || rd2 !== 16'h0000) begin n_fail++; $display("FAIL wr_r0_read: got %h/%h expected 0000/0000", rd1, rd2); end
    endtask

    task automatic test_same_cycle();
        logic [DATA_W-1:0] exp_v;
        exp_v = BYPASS ? 16'h1234 : 16'h0000;
        we = 1; wa = 5; wd = 16'h1234; re = 1; ra1 = 2; ra2 = 5;
        tick();
        n_checks++; if (rd2 !== exp_v) begin n_fail++; $display("FAIL same_cycle_rd2: got %h expected %h", rd2, exp_v); end
        re = 1; ra1 = 5; ra2 = 5;
        tick();
        n_checks++; if (rd1 !== 16'h1234 || rd2 !== 16'h1234) begin n_fail++; $display("FAIL same_addr_both: got %h/%h expected 1234/1234", rd1, rd2); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1; rsv_a = 4;
        tick();
        re = 1; ra1 = 4; ra2 = 3;
        tick();
        n_checks++; if (busy1 !== 1'b1 || busy2 !== 1'b0) begin n_fail++; $display("FAIL sb_reserve: got %b/%b expected 1/0", busy1, busy2); end
        we = 1; wa = 4; wd = 16'h7777; re = 1; ra1 = 4;
        tick();
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_complete: busy1 got %b expected 0", busy1); end
        n_checks++; if (rd1 !== m_rd1) begin n_fail++; $display("FAIL sb_complete_rd: got %h expected %h", rd1, m_rd1); end
        rsv_en = 1; rsv_a = 6; we = 1; wa = 6; wd = 16'h5A5A;
        tick();
        re = 1; ra1 = 6; ra2 = 6;
        tick();
        n_checks++; if (busy1 !== 1'b1 || busy2 !== 1'b1) begin n_fail++; $display("FAIL sb_rsv_wins: got %b/%b expected 1/1", busy1, busy2); end
        n_checks++; if (rd1 !== 16'h5A5A || rd2 !== 16'h5A5A) begin n_fail++; $display("FAIL sb_rsv_data: got %h/%h expected 5a5a/5a5a", rd1, rd2); end
        // A reserve issued alongside the read is not yet visible.
        rsv_en = 1; rsv_a = 2; re = 1; ra1 = 2; ra2 = 0;
        tick();
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL sb_rsv_same_read: busy1 got %b expected 0", busy1); end
        rsv_en = 1; rsv_a = 0;
        tick();
        re = 1; ra1 = 0; ra2 = 2;
        tick();
        n_checks++; if (busy1 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL sb_r0_never_busy: got %b/%b expected 0/1", busy1, busy2); end
    endtask

    task automatic test_pc();
        logic [DATA_W-1:0] exp_v;
        exp_v = BYPASS ? 16'h0010 : 16'h0000;
        pc_we = 1; pc_next = 16'h0010; re = 1; ra1 = 0; ra2 = 1;
        tick();
        n_checks++; if (rd1 !== exp_v) begin n_fail++; $display("FAIL pc_read_same: got %h expected %h", rd1, exp_v); end
        n_checks++; if (pc !== 16'h0010) begin n_fail++; $display("FAIL pc_update: got %h expected 0010", pc); end
        // PC and general writes in one cycle are independent.
        pc_we = 1; pc_next = 16'h0014; we = 1; wa = 7; wd = 16'hBEEF;
        tick();
        re = 1; ra1 = 7; ra2 = 0;
        tick();
        n_checks++; if (rd1 !== 16'hBEEF || rd2 !== 16'h0014 || pc !== 16'h0014) begin n_fail++; $display("FAIL pc_and_wr: got %h/%h/%h expected beef/0014/0014", rd1, rd2, pc); end
    endtask

    task automatic test_hold();
        logic [DATA_W-1:0] s1, s2;
        logic sb1, sb2;
        s1 = rd1; s2 = rd2; sb1 = busy1; sb2 = busy2;
        for (int k = 0; k < 4; k++) begin
            re = 0; ra1 = ADDR_W'($urandom_range(0, 7)); ra2 = ADDR_W'($urandom_range(0, 7));
            we = 1; wa = ADDR_W'($urandom_range(1, 7)); wd = DATA_W'($urandom);
            rsv_en = 1; rsv_a = ADDR_W'($urandom_range(1, 7));
            tick();
        end
        n_checks++; if (rd1 !== s1 || rd2 !== s2 || busy1 !== sb1 || busy2 !== sb2) begin n_fail++; $display("FAIL re_hold: got %h/%h/%b/%b expected %h/%h/%b/%b", rd1, rd2, busy1, busy2, s1, s2, sb1, sb2); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            re      = ($urandom_range(0, 3) != 0);
            ra1     = ADDR_W'($urandom_range(0, 7));
            ra2     = ($urandom_range(0, 4) == 0) ? ra1 : ADDR_W'($urandom_range(0, 7));
            we      = $urandom_range(0, 1);
            wa      = ($urandom_range(0, 2) == 0) ? ra1 : ADDR_W'($urandom_range(0, 7));
            wd      = DATA_W'($urandom);
            pc_we   = ($urandom_range(0, 3) == 0);
            pc_next = DATA_W'($urandom);
            rsv_en  = ($urandom_range(0, 2) == 0);
            rsv_a   = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, 7));
            tick();
            n_checks++;
            if (rd1 !== m_rd1 || rd2 !== m_rd2 || busy1 !== m_b1 || busy2 !== m_b2 || pc !== m_regs[0]) begin
                n_fail++;
                $display("FAIL random[%0d]: got rd %h/%h busy %b/%b pc %h expected rd %h/%h busy %b/%b pc %h",
                         k, rd1, rd2, busy1, busy2, pc, m_rd1, m_rd2, m_b1, m_b2, m_regs[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #3;
        re = 1; ra1 = 2; ra2 = 3; we = 1; wa = 2; wd = 16'hFFFF;
        pc_we = 1; pc_next = 16'h0F0F; rsv_en = 1; rsv_a = 3;
        reset = 1'b1;
        #1;
        n_checks++; if (pc !== 16'h0 || rd1 !== 16'h0 || rd2 !== 16'h0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_mid_async: got pc %h rd %h/%h busy %b/%b expected all zero", pc, rd1, rd2, busy1, busy2); end
        @(posedge clk); #1;
        n_checks++; if (pc !== 16'h0 || rd1 !== 16'h0) begin n_fail++; $display("FAIL reset_mid_dominant: got pc %h rd1 %h expected 0000/0000", pc, rd1); end
        re = 0; we = 0; pc_we = 0; rsv_en = 0;
        reset = 1'b0;
        model_reset();
        for (int a = 0; a < NUM_REGS; a += 2) begin
            re = 1; ra1 = ADDR_W'(a + 1); ra2 = ADDR_W'((a + 2) % NUM_REGS);
            tick();
            n_checks++;
            if (rd1 !== m_regs[ra1] || rd2 !== m_regs[ra2] || busy1 !== 1'b0 || busy2 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_regs r%0d/r%0d: got %h/%h busy %b/%b expected %h/%h busy 0/0",
                         ra1, ra2, rd1, rd2, busy1, busy2, m_regs[ra1], m_regs[ra2]);
            end
        end
        re = 1; ra1 = 1; ra2 = 0;
        tick();
        n_checks++; if (rd1 !== 16'h0004 || rd2 !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_r1: got %h/%h expected 0004/0000", rd1, rd2); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_cycle();
        test_scoreboard();
        test_pc();
        test_hold();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
